// File: rtl/ex_stage_pkg.sv
// Shared types for the EX stage: ALU opcodes, register widths and divider FSM states.
package ex_stage_pkg;

  localparam int ALU_OP_W   = 8;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP   = 8'h00,
    ALU_ADD   = 8'h01,
    ALU_ADDU  = 8'h02,
    ALU_SUB   = 8'h03,
    ALU_SUBU  = 8'h04,
    ALU_AND   = 8'h05,
    ALU_OR    = 8'h06,
    ALU_XOR   = 8'h07,
    ALU_NOR   = 8'h08,
    ALU_SLT   = 8'h09,
    ALU_SLTU  = 8'h0A,
    ALU_SLL   = 8'h0B,
    ALU_SRL   = 8'h0C,
    ALU_SRA   = 8'h0D,
    ALU_LUI   = 8'h0E,
    ALU_MULT  = 8'h10,
    ALU_MULTU = 8'h11,
    ALU_DIV   = 8'h12,
    ALU_DIVU  = 8'h13,
    ALU_MTHI  = 8'h14,
    ALU_MTLO  = 8'h15,
    ALU_MFHI  = 8'h16,
    ALU_MFLO  = 8'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative radix-2 restoring divider, 32 steps; only built when MANGO_DIV_EN is defined.
`ifdef MANGO_DIV_EN
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] opr1,
  input  logic [31:0] opr2,
  input  logic        abort,
  input  logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] dsr_q, quo_q, rem_q;
  logic        neg_quo_q, neg_rem_q;
  logic        s1, s2, by_zero, ge;
  logic [31:0] abs1, abs2;
  logic [32:0] partial, diff;

  assign s1      = signed_op && opr1[31];
  assign s2      = signed_op && opr2[31];
  assign abs1    = s1 ? -opr1 : opr1;
  assign abs2    = s2 ? -opr2 : opr2;
  assign by_zero = (opr2 == ZERO_WORD);

  // rem_q < dsr_q always holds, so bit 32 of the trial difference is a clean borrow flag.
  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dsr_q};
  assign ge      = !diff[32];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start) state_d = by_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (count_q == 5'd31) state_d = DIV_DONE;
      DIV_DONE: if (!stall) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (abort) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= 5'd0;
      dsr_q     <= ZERO_WORD;
      quo_q     <= ZERO_WORD;
      rem_q     <= ZERO_WORD;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == DIV_IDLE && start && !abort) begin
      count_q <= 5'd0;
      dsr_q   <= abs2;
      if (by_zero) begin
        quo_q     <= 32'hFFFF_FFFF;
        rem_q     <= opr1;
        neg_quo_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end else begin
        quo_q     <= abs1;
        rem_q     <= ZERO_WORD;
        neg_quo_q <= s1 ^ s2;
        neg_rem_q <= s1;
      end
    end else if (state_q == DIV_BUSY && !abort) begin
      count_q <= count_q + 5'd1;
      rem_q   <= ge ? diff[31:0] : partial[31:0];
      quo_q   <= {quo_q[30:0], ge};
    end
  end

  assign busy      = (state_q == DIV_BUSY);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;

endmodule
`endif

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO with MULT/MTxx/MFxx, optional iterative divider (MANGO_DIV_EN).
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [31:0]           ex_pc,
  input  logic [ALU_OP_W-1:0]   ex_aluop,
  input  logic [31:0]           ex_opr1,
  input  logic [31:0]           ex_opr2,
  input  logic [REG_ADDR_W-1:0] ex_wraddr,
  input  logic                  ex_wreg,
  output logic [31:0]           ex_wdata_o,
  output logic [REG_ADDR_W-1:0] ex_wraddr_o,
  output logic                  ex_wreg_o,
  output logic [31:0]           ex_pc_o,
  output logic                  ov,
  output logic                  stallreq
);

  alu_op_e     op;
  logic [31:0] hi_q, lo_q, add_res, sub_res, alu_res;
  logic [63:0] mul_a, mul_b, prod;
  logic [4:0]  shamt;
  logic        signed_mul, ov_add, ov_sub, no_wb;
  logic        div_done;
  logic [31:0] div_quo, div_rem;

  assign op      = alu_op_e'(ex_aluop);
  assign shamt   = ex_opr1[4:0];
  assign add_res = ex_opr1 + ex_opr2;
  assign sub_res = ex_opr1 - ex_opr2;
  assign ov_add  = (ex_opr1[31] == ex_opr2[31]) && (add_res[31] != ex_opr1[31]);
  assign ov_sub  = (ex_opr1[31] != ex_opr2[31]) && (sub_res[31] != ex_opr1[31]);

  // Extending both operands to 64 bits lets one multiplier serve MULT and MULTU.
  assign signed_mul = (op == ALU_MULT);
  assign mul_a      = {{32{signed_mul & ex_opr1[31]}}, ex_opr1};
  assign mul_b      = {{32{signed_mul & ex_opr2[31]}}, ex_opr2};
  assign prod       = mul_a * mul_b;

  always_comb begin
    alu_res = ZERO_WORD;
    no_wb   = 1'b0;
    ov      = 1'b0;
    case (op)
      ALU_ADD:  begin alu_res = add_res; ov = ov_add; end
      ALU_ADDU: alu_res = add_res;
      ALU_SUB:  begin alu_res = sub_res; ov = ov_sub; end
      ALU_SUBU: alu_res = sub_res;
      ALU_AND:  alu_res = ex_opr1 & ex_opr2;
      ALU_OR:   alu_res = ex_opr1 | ex_opr2;
      ALU_XOR:  alu_res = ex_opr1 ^ ex_opr2;
      ALU_NOR:  alu_res = ~(ex_opr1 | ex_opr2);
      ALU_SLT:  alu_res = {31'd0, $signed(ex_opr1) < $signed(ex_opr2)};
      ALU_SLTU: alu_res = {31'd0, ex_opr1 < ex_opr2};
      ALU_SLL:  alu_res = ex_opr2 << shamt;
      ALU_SRL:  alu_res = ex_opr2 >> shamt;
      ALU_SRA:  alu_res = $signed(ex_opr2) >>> shamt;
      ALU_LUI:  alu_res = {ex_opr2[15:0], 16'h0000};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      ALU_NOP, ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO: no_wb = 1'b1;
      default:  alu_res = ZERO_WORD;
    endcase
  end

  assign ex_wdata_o  = alu_res;
  assign ex_wreg_o   = ex_wreg && !no_wb && !ov;
  assign ex_wraddr_o = ex_wraddr;
  assign ex_pc_o     = ex_pc;

`ifdef MANGO_DIV_EN
  logic is_div, div_busy, div_start;

  assign is_div    = (op == ALU_DIV) || (op == ALU_DIVU);
  assign div_start = is_div && !flush && !div_busy && !div_done;
  // Gated by rst so the request drops the moment reset is asserted, not at the next edge.
  assign stallreq  = rst && is_div && !flush && !div_done;

  div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (op == ALU_DIV),
    .opr1      (ex_opr1),
    .opr2      (ex_opr2),
    .abort     (flush),
    .stall     (stall),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );
`else
  assign div_done = 1'b0;
  assign div_quo  = ZERO_WORD;
  assign div_rem  = ZERO_WORD;
  assign stallreq = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else if (!stall && !flush) begin
      if (div_done) begin
        hi_q <= div_rem;
        lo_q <= div_quo;
      end else begin
        case (op)
          ALU_MULT, ALU_MULTU: begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end
          ALU_MTHI: hi_q <= ex_opr1;
          ALU_MTLO: lo_q <= ex_opr1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, ports first:
- clk      in   1   rising-edge clock
- rst      in   1   asynchronous, active-low reset
REQ-002 SHALL have these control inputs:
- stall    in   1   downstream/global stall; block holds state
- flush    in   1   kills the instruction in EX
REQ-003 SHALL have these ID/EX-register inputs:
- ex_pc      in   32            instruction PC
- ex_aluop   in   `ALUOp        operation code
- ex_opr1    in   32            operand 1 (rs)
- ex_opr2    in   32            operand 2 (rt/imm)
- ex_wraddr  in   `RegAddr (5)  destination register
- ex_wreg    in   1             destination write enable
REQ-004 SHALL have these outputs to the EX/MEM register:
- ex_wdata_o   out  32   result
- ex_wraddr_o  out  5    destination register
- ex_wreg_o    out  1    write enable
- ex_pc_o      out  32   PC passthrough
- ov           out  1    signed overflow on ADD/SUB
- stallreq     out  1    EX requests pipeline stall

Function
REQ-005 SHALL compute combinationally ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA and LUI; shift amount is opr1[4:0].
REQ-006 SHALL assert ov on ADD/SUB two's-complement overflow and force ex_wreg_o=0 in that case; ADDU/SUBU never set ov.
REQ-007 SHALL hold internal 32-bit HI and LO registers, written only on a clock edge with stall=0 and flush=0.
REQ-008 SHALL on MULT/MULTU form a 64-bit signed/unsigned product in one cycle and write HI<=prod[63:32], LO<=prod[31:0].
REQ-009 SHALL on MTHI/MTLO write opr1 to HI or LO; MFHI/MFLO SHALL return the current HI or LO on ex_wdata_o.
REQ-010 SHALL implement DIV/DIVU with a divider FSM:
- IDLE: a DIV/DIVU seen with flush=0 latches |opr1| and |opr2|, the signs and a 5-bit count=0, then goes to BUSY.
- BUSY: one radix-2 restoring step per cycle for 32 cycles; count wraps 31->0 and the FSM moves to DONE.
- DONE: result is valid; the FSM stays in DONE while stall=1, otherwise writes HI<=remainder and LO<=quotient and returns to IDLE.
REQ-011 SHALL assert stallreq combinationally while a DIV/DIVU is in EX and the FSM is in IDLE or BUSY; stallreq SHALL be 0 in DONE; DIV occupies EX for 34 cycles.
REQ-012 SHALL apply signed division rules: quotient sign = s1^s2, remainder sign = s1.
REQ-013 SHALL handle the division boundary cases as follows:
- 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
- Divide-by-zero SHALL go IDLE->DONE directly, with LO=0xFFFFFFFF and HI=opr1.
REQ-014 SHALL on flush=1 in any FSM state return the FSM to IDLE next cycle, deassert stallreq and leave HI/LO unwritten.
REQ-015 SHALL pass ex_wraddr, ex_pc and ex_wreg to the outputs unchanged, except as stated in REQ-006.
REQ-016 SHALL make ex_wreg_o=0 for ALU_NOP, MULT/MULTU, DIV/DIVU and MTHI/MTLO.

Reset
REQ-017 SHALL on rst=0, asynchronously and regardless of clk, set HI=LO=0x00000000, FSM=IDLE, count=0, divider datapath=0 and stallreq=0.
REQ-018 SHALL on reset mid-division abort the division with no HI/LO write; after release, an in-flight DIV restarts from IDLE.

Configuration
REQ-019 SHALL use macro MANGO_DIV_EN.
- Defined: the divider (REQ-010 to REQ-014) is present.
- Undefined: DIV/DIVU act as ALU_NOP, stallreq is tied to 0, HI/LO are unchanged and no divider logic is synthesized.

Structure
REQ-020 SHALL take `ALUOp, the ALU_* opcodes, `RegAddr, `ZeroWord, `ZeroReg, `true/`false and the FSM state encodings from shared defines.v.
REQ-021 SHALL place the iterative divider in one sub-module div_iter with signals start, signed_op, opr1, opr2, abort, stall, busy, done, quotient and remainder.

Verification
REQ-022 SHALL cover ADD 0x7FFFFFFF+1: ov=1, ex_wreg_o=0; ADDU of the same operands: wdata=0x80000000, ov=0.
REQ-023 SHALL cover MULT 0xFFFFFFFE*3 then MFHI/MFLO: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-024 SHALL cover DIV -7/2: stallreq high for 33 cycles; then HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3).
REQ-025 SHALL cover DIVU 100/0: DONE after 1 cycle, LO=0xFFFFFFFF, HI=100.
REQ-026 SHALL cover flush at BUSY count=10: FSM IDLE next cycle, stallreq=0, HI/LO unchanged.
REQ-027 SHALL cover rst=0 pulse between clock edges mid-BUSY: HI=LO=0 and stallreq=0 immediately, before the next clk edge.
